// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter sharing one variable-latency memory between
//               the instruction-fetch path and the data-access path. Grants
//               one requester at a time, handshakes completion with a
//               one-cycle ack, stalls the CPU while a request is pending and
//               aborts accesses that exceed TIMEOUT cycles.
//               Optional feature: define MEM_ARBITER_RR_EN for round-robin
//               tie-breaking. Otherwise data wins over fetch on a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          cpu_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT-1
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_owner_d;      // 1 = data port owns the memory, 0 = fetch
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            w_any_req;
    logic            w_grant_d;
    logic            w_timeout;

    assign w_any_req = if_req | d_req;

`ifdef MEM_ARBITER_RR_EN
    // On a tie the port that did not own the last access wins
    assign w_grant_d = d_req & ~(if_req & r_owner_d);
`else
    // Data always beats fetch; fetch may starve under continuous d_req
    assign w_grant_d = d_req;
`endif

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state: grant in IDLE, finish on ready or timeout, ACK lasts one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = BUSY;
            BUSY:    if (mem_ready || w_timeout) w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant: latch owner and the memory command, clear the timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner_d <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
            if (w_any_req) begin
                r_owner_d <= w_grant_d;
                r_we      <= w_grant_d & d_we;
                r_addr    <= w_grant_d ? d_addr  : if_addr;
                r_wdata   <= w_grant_d ? d_wdata : '0;
            end
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Completion: capture read data for the owner or record a timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (r_state == BUSY) begin
            if (mem_ready) begin
                r_err <= 1'b0;
                if (!r_owner_d)  r_if_rdata <= mem_rdata;
                else if (!r_we)  r_d_rdata  <= mem_rdata;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req   = (r_state == BUSY);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ack    = (r_state == ACK) & ~r_owner_d;
    assign d_ack     = (r_state == ACK) &  r_owner_d;
    assign if_err    = if_ack & r_err;
    assign d_err     = d_ack  & r_err;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

    assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (TIMEOUT = 4).
//               Expectations follow MEM_ARBITER_RR_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          cpu_stall;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .cpu_stall (cpu_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        step();
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_acks",     {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata",  d_rdata,  32'd0);
        reset = 1'b1;

        // ---- single fetch, mem_ready on first BUSY cycle ----
        step();
        if_req = 1'b1; if_addr = 32'h0000_0040; #1;                    // cycle 0
        chk("f_c0_stall",   {31'd0, cpu_stall}, 32'd1);
        chk("f_c0_memreq",  {31'd0, mem_req},   32'd0);
        step();                                                        // cycle 1
        chk("f_c1_memreq",  {31'd0, mem_req},   32'd1);
        chk("f_c1_addr",    mem_addr, 32'h0000_0040);
        chk("f_c1_we",      {31'd0, mem_we},    32'd0);
        chk("f_c1_stall",   {31'd0, cpu_stall}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        step();                                                        // cycle 2
        mem_ready = 1'b0; mem_rdata = '0;
        chk("f_c2_ack",     {31'd0, if_ack},    32'd1);
        chk("f_c2_rdata",   if_rdata, 32'h2008_0005);
        chk("f_c2_err",     {31'd0, if_err},    32'd0);
        chk("f_c2_stall",   {31'd0, cpu_stall}, 32'd0);
        chk("f_c2_memreq",  {31'd0, mem_req},   32'd0);
        if_req = 1'b0;
        step();                                                        // cycle 3
        chk("f_c3_ack",     {31'd0, if_ack},    32'd0);

        // ---- store, memory latency 3 ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        step();                                                        // cycle 1
        chk("s_c1_we",      {31'd0, mem_we},    32'd1);
        chk("s_c1_addr",    mem_addr, 32'h100);
        chk("s_c1_wdata",   mem_wdata, 32'hCAFE_F00D);
        step();                                                        // cycle 2
        chk("s_c2_memreq",  {31'd0, mem_req},   32'd1);
        step();                                                        // cycle 3
        chk("s_c3_memreq",  {31'd0, mem_req},   32'd1);
        chk("s_c3_we",      {31'd0, mem_we},    32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();                                                        // cycle 4
        mem_ready = 1'b0;
        chk("s_c4_ack",     {31'd0, d_ack},     32'd1);
        chk("s_c4_err",     {31'd0, d_err},     32'd0);
        chk("s_c4_rdata",   d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        step();

        // ---- simultaneous fetch and load, both held ----
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
        step();                                                        // cycle 1
`ifdef MEM_ARBITER_RR_EN
        chk("t_first_addr", mem_addr, 32'h44);
        mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        step();                                                        // cycle 2
        mem_ready = 1'b0;
        chk("t_first_ack",  {30'd0, if_ack, d_ack}, 32'd2);
        chk("t_first_data", if_rdata, 32'h3333_4444);
        if_req = 1'b0;
        step(); step();                                                // cycle 4
        chk("t_second_addr", mem_addr, 32'h204);
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        step();                                                        // cycle 5
        mem_ready = 1'b0;
        chk("t_second_ack", {30'd0, if_ack, d_ack}, 32'd1);
        chk("t_second_data", d_rdata, 32'h1111_2222);
        d_req = 1'b0;
`else
        chk("t_first_addr", mem_addr, 32'h204);
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        step();                                                        // cycle 2
        mem_ready = 1'b0;
        chk("t_first_ack",  {30'd0, if_ack, d_ack}, 32'd1);
        chk("t_first_data", d_rdata, 32'h1111_2222);
        chk("t_if_stall",   {31'd0, cpu_stall}, 32'd1);
        d_req = 1'b0;
        step(); step();                                                // cycle 4
        chk("t_second_addr", mem_addr, 32'h44);
        mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        step();                                                        // cycle 5
        mem_ready = 1'b0;
        chk("t_second_ack", {30'd0, if_ack, d_ack}, 32'd2);
        chk("t_second_data", if_rdata, 32'h3333_4444);
        if_req = 1'b0;
`endif
        step();

        // ---- fetch timeout, TIMEOUT = 4 ----
        if_req = 1'b1; if_addr = 32'h80;
        step(); step(); step(); step();                                // cycle 4
        chk("to_c4_memreq", {31'd0, mem_req},   32'd1);
        chk("to_c4_ack",    {31'd0, if_ack},    32'd0);
        step();                                                        // cycle 5
        chk("to_c5_ack",    {31'd0, if_ack},    32'd1);
        chk("to_c5_err",    {31'd0, if_err},    32'd1);
        chk("to_c5_rdata",  if_rdata, 32'h3333_4444);
        chk("to_c5_memreq", {31'd0, mem_req},   32'd0);
        if_req = 1'b0;
        step();                                                        // cycle 6
        chk("to_c6_ack",    {31'd0, if_ack},    32'd0);

        // ---- mem_ready in the timeout cycle wins ----
        if_req = 1'b1; if_addr = 32'h84;
        step(); step(); step(); step();                                // cycle 4
        mem_ready = 1'b1; mem_rdata = 32'h5555_6666;
        step();                                                        // cycle 5
        mem_ready = 1'b0;
        chk("rw_ack",       {31'd0, if_ack},    32'd1);
        chk("rw_err",       {31'd0, if_err},    32'd0);
        chk("rw_rdata",     if_rdata, 32'h5555_6666);
        if_req = 1'b0;
        step();

        // ---- reset mid-BUSY, held d_req re-granted ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        step();                                                        // BUSY
        chk("ar_busy",      {31'd0, mem_req},   32'd1);
        #2 reset = 1'b0; #1;
        chk("ar_async_drop", {31'd0, mem_req},  32'd0);
        chk("ar_rdata_clr", if_rdata, 32'd0);
        step();
        chk("ar_no_ack",    {30'd0, if_ack, d_ack}, 32'd0);
        reset = 1'b1;
        step();
        chk("ar_regrant",   {31'd0, mem_req},   32'd1);
        chk("ar_addr",      mem_addr, 32'h200);
        mem_ready = 1'b1; mem_rdata = 32'h7777_8888;
        step();
        mem_ready = 1'b0;
        chk("ar_ack",       {31'd0, d_ack},     32'd1);
        chk("ar_data",      d_rdata, 32'h7777_8888);
        d_req = 1'b0;
        step();

        // ---- mem_ready while IDLE is ignored ----
        mem_ready = 1'b1; mem_rdata = 32'h9999_AAAA;
        step();
        chk("ir_acks",      {30'd0, if_ack, d_ack}, 32'd0);
        chk("ir_memreq",    {31'd0, mem_req},   32'd0);
        mem_ready = 1'b0;
        step();
        chk("ir_acks2",     {30'd0, if_ack, d_ack}, 32'd0);
        chk("ir_data",      d_rdata, 32'h7777_8888);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
